// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce_event button conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } chan_state_e;

  // Bits needed to count 0..num_values-1; never narrower than one bit.
  function automatic int cnt_width(input int num_values);
    return (num_values <= 1) ? 1 : $clog2(num_values);
  endfunction

endpackage

// File: rtl/debounce_event_channel.sv
// One button channel: two-flop synchroniser, tick-sampled stability filter and
// RELEASED/PRESSED/HELD state machine driving registered level and event pulses.
module debounce_event_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS  = 4,
  parameter int LONG_TICKS    = 100,
  parameter int REPEAT_TICKS  = 20,
  parameter int PRESSED_STATE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_long_tick,
  input  logic i_button,
  output logic o_button,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int CNT_W  = cnt_width(STABLE_TICKS);
  localparam int HOLD_W = cnt_width(LONG_TICKS + 1);
  localparam int REP_W  = cnt_width(REPEAT_TICKS + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_ZERO    = {REP_W{1'b0}};
  localparam logic [REP_W-1:0]  REP_ONE     = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_MAX     = REP_W'(REPEAT_TICKS);
  localparam logic              ACTIVE_HIGH = (PRESSED_STATE != 0);

  logic [1:0]        sync_r;
  logic              sample_s;
  logic              accept_s;
  logic              level_r, level_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  chan_state_e       state_r, state_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [REP_W-1:0]  rep_r, rep_s;
  logic              press_r, press_s;
  logic              release_r, release_s;
  logic              long_r, long_s;
  logic              repeat_r, repeat_s;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], i_button};
    end
  end

  assign sample_s = ACTIVE_HIGH ? sync_r[1] : ~sync_r[1];

  // Stability filter: a change is accepted only after STABLE_TICKS disagreeing samples in a row.
  always_comb begin
    cnt_s    = cnt_r;
    level_s  = level_r;
    accept_s = 1'b0;
    if (i_long_tick) begin
      if (sample_s == level_r) begin
        cnt_s = CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        accept_s = 1'b1;
        level_s  = sample_s;
        cnt_s    = CNT_ZERO;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Hold/repeat state machine; a release accepted on a threshold tick suppresses long/repeat.
  always_comb begin
    state_s   = state_r;
    hold_s    = hold_r;
    rep_s     = rep_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    long_s    = 1'b0;
    repeat_s  = 1'b0;
    if (i_long_tick) begin
      case (state_r)
        ST_RELEASED: begin
          hold_s = HOLD_ZERO;
          rep_s  = REP_ZERO;
          if (accept_s && sample_s) begin
            state_s = ST_PRESSED;
            press_s = 1'b1;
          end else begin
            state_s = ST_RELEASED;
          end
        end
        ST_PRESSED: begin
          if (accept_s && !sample_s) begin
            state_s   = ST_RELEASED;
            hold_s    = HOLD_ZERO;
            rep_s     = REP_ZERO;
            release_s = 1'b1;
          end else begin
            hold_s = (hold_r == HOLD_MAX) ? hold_r : hold_r + HOLD_ONE;
            if (hold_s == HOLD_MAX) begin
              state_s = ST_HELD;
              rep_s   = REP_ZERO;
              long_s  = 1'b1;
            end else begin
              state_s = ST_PRESSED;
            end
          end
        end
        ST_HELD: begin
          if (accept_s && !sample_s) begin
            state_s   = ST_RELEASED;
            hold_s    = HOLD_ZERO;
            rep_s     = REP_ZERO;
            release_s = 1'b1;
          end else if (REPEAT_TICKS > 0) begin
            rep_s = rep_r + REP_ONE;
            if (rep_s == REP_MAX) begin
              rep_s    = REP_ZERO;
              repeat_s = 1'b1;
            end else begin
              repeat_s = 1'b0;
            end
          end else begin
            rep_s = rep_r;
          end
        end
        default: begin
          state_s = ST_RELEASED;
          hold_s  = HOLD_ZERO;
          rep_s   = REP_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Filter, state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_r   <= 1'b0;
      cnt_r     <= CNT_ZERO;
      state_r   <= ST_RELEASED;
      hold_r    <= HOLD_ZERO;
      rep_r     <= REP_ZERO;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
    end else begin
      level_r   <= level_s;
      cnt_r     <= cnt_s;
      state_r   <= state_s;
      hold_r    <= hold_s;
      rep_r     <= rep_s;
      press_r   <= press_s;
      release_r <= release_s;
      long_r    <= long_s;
      repeat_r  <= repeat_s;
    end
  end

  assign o_button  = level_r;
  assign o_press   = press_r;
  assign o_release = release_r;
  assign o_long    = long_r;
  assign o_repeat  = repeat_r;

endmodule

// File: rtl/debounce_event.sv
// Multi-channel button conditioner: N independent debounce/long-press channels
// sharing one sample tick.
module debounce_event
  import debounce_pkg::*;
#(
  parameter int N             = 4,
  parameter int STABLE_TICKS  = 4,
  parameter int LONG_TICKS    = 100,
  parameter int REPEAT_TICKS  = 20,
  parameter int PRESSED_STATE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_long_tick,
  input  logic [N-1:0] i_button,
  output logic [N-1:0] o_button,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic [N-1:0] o_long,
  output logic [N-1:0] o_repeat
);

  for (genvar ch = 0; ch < N; ch++) begin : g_chan
    debounce_event_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .PRESSED_STATE(PRESSED_STATE)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_long_tick(i_long_tick),
      .i_button   (i_button[ch]),
      .o_button   (o_button[ch]),
      .o_press    (o_press[ch]),
      .o_release  (o_release[ch]),
      .o_long     (o_long[ch]),
      .o_repeat   (o_repeat[ch])
    );
  end

endmodule
